// File: rtl/mult64_arb_ctrl_if.sv
// mult64_arb_ctrl_if: requester, multiplier and result bundles
// of the shared 64x64 multiplier front end.
interface mult64_arb_ctrl_if;
    logic         i_req0_valid;
    logic         i_req1_valid;
    logic         o_req0_ready;
    logic         o_req1_ready;
    logic [63:0]  i_req0_a;
    logic [63:0]  i_req0_b;
    logic [63:0]  i_req1_a;
    logic [63:0]  i_req1_b;
    logic         i_req0_a_ns;
    logic         i_req0_b_ns;
    logic         i_req1_a_ns;
    logic         i_req1_b_ns;
    logic [63:0]  o_mult_a;
    logic [63:0]  o_mult_b;
    logic         o_mult_a_ns;
    logic         o_mult_b_ns;
    logic [127:0] i_mult_p;
    logic         o_res_valid;
    logic         i_res_ready;
    logic [127:0] o_res_p;
    logic         o_res_id;
    logic         o_busy;

    modport slave (
        input  i_req0_valid, i_req1_valid,
        input  i_req0_a, i_req0_b, i_req1_a, i_req1_b,
        input  i_req0_a_ns, i_req0_b_ns, i_req1_a_ns, i_req1_b_ns,
        input  i_mult_p, i_res_ready,
        output o_req0_ready, o_req1_ready,
        output o_mult_a, o_mult_b, o_mult_a_ns, o_mult_b_ns,
        output o_res_valid, o_res_p, o_res_id, o_busy
    );

    modport master (
        output i_req0_valid, i_req1_valid,
        output i_req0_a, i_req0_b, i_req1_a, i_req1_b,
        output i_req0_a_ns, i_req0_b_ns, i_req1_a_ns, i_req1_b_ns,
        output i_mult_p, i_res_ready,
        input  o_req0_ready, o_req1_ready,
        input  o_mult_a, o_mult_b, o_mult_a_ns, o_mult_b_ns,
        input  o_res_valid, o_res_p, o_res_id, o_busy
    );
endinterface

// File: rtl/mult64_arb_ctrl.sv
// mult64_arb_ctrl: round-robin arbiter feeding a shared pipelined
// 64x64 multiplier, with a credit-gated in-order result FIFO.
module mult64_arb_ctrl #(
    parameter int MULT_LAT  = 3,
    parameter int RES_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mult64_arb_ctrl_if.slave bus
);
    localparam int CW = $clog2(RES_DEPTH + MULT_LAT + 1);
    localparam int PW = $clog2(RES_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(RES_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] LAST_C  = PW'(RES_DEPTH - 1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

    logic                last;
    logic [MULT_LAT-1:0] pv;
    logic [MULT_LAT-1:0] pid;
    logic [CW-1:0]       inflight;
    logic [CW-1:0]       cnt;
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       rptr;
    logic [127:0]        mem_p  [RES_DEPTH];
    logic                mem_id [RES_DEPTH];
    logic [63:0]         ma;
    logic [63:0]         mb;
    logic                ma_ns;
    logic                mb_ns;

    logic credit_ok;
    logic grant;
    logic accept;
    logic push;
    logic pop;
    logic res_valid;

    // Both valid: the side not granted last wins.
    assign grant = bus.i_req1_valid
                 & (~bus.i_req0_valid | ~last);

    assign credit_ok = ~i_rst & ((inflight + cnt) < DEPTH_C);

    assign bus.o_req0_ready = credit_ok & ~grant;
    assign bus.o_req1_ready = credit_ok & grant;

    assign accept = (bus.i_req0_valid & bus.o_req0_ready)
                  | (bus.i_req1_valid & bus.o_req1_ready);

    assign push      = pv[MULT_LAT-1];
    assign res_valid = ~i_rst & (cnt != '0);
    assign pop       = res_valid & bus.i_res_ready;

    assign bus.o_res_valid = res_valid;
    assign bus.o_res_p     = i_rst ? '0 : mem_p[rptr];
    assign bus.o_res_id    = i_rst ? 1'b0 : mem_id[rptr];
    assign bus.o_busy      = ~i_rst & ((inflight != '0) | (cnt != '0));

    assign bus.o_mult_a    = ma;
    assign bus.o_mult_b    = mb;
    assign bus.o_mult_a_ns = ma_ns;
    assign bus.o_mult_b_ns = mb_ns;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last  <= 1'b1;
            ma    <= '0;
            mb    <= '0;
            ma_ns <= 1'b0;
            mb_ns <= 1'b0;
        end else if (accept) begin
            last  <= grant;
            ma    <= grant ? bus.i_req1_a : bus.i_req0_a;
            mb    <= grant ? bus.i_req1_b : bus.i_req0_b;
            ma_ns <= grant ? bus.i_req1_a_ns : bus.i_req0_a_ns;
            mb_ns <= grant ? bus.i_req1_b_ns : bus.i_req0_b_ns;
        end
    end

    // Valid/id shift pipe tracks which product emerges on i_mult_p.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pv <= '0;
        end else begin
            pv[0] <= accept;
            for (int i = 1; i < MULT_LAT; i++) begin
                pv[i] <= pv[i-1];
            end
        end
        pid[0] <= grant;
        for (int i = 1; i < MULT_LAT; i++) begin
            pid[i] <= pid[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight <= '0;
        end else if (accept && !push) begin
            inflight <= inflight + ONE_C;
        end else if (push && !accept) begin
            inflight <= inflight - ONE_C;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt  <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                mem_p[wptr]  <= bus.i_mult_p;
                mem_id[wptr] <= pid[MULT_LAT-1];
                wptr <= (wptr == LAST_C) ? '0 : wptr + PONE_C;
            end
            if (pop) begin
                rptr <= (rptr == LAST_C) ? '0 : rptr + PONE_C;
            end
            if (push && !pop) begin
                cnt <= cnt + ONE_C;
            end else if (pop && !push) begin
                cnt <= cnt - ONE_C;
            end
        end
    end

    a_no_push_full: assert property (
        @(posedge i_clk) disable iff (i_rst)
        push |-> (cnt != DEPTH_C)
    );
endmodule

// File: tb/tb_mult64_arb_ctrl.sv
// tb_mult64_arb_ctrl: directed vectors with a queue scoreboard and
// a 3-cycle behavioural model of the shared multiplier.
module tb_mult64_arb_ctrl;
    localparam int MULT_LAT  = 3;
    localparam int RES_DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    mult64_arb_ctrl_if bus ();

    mult64_arb_ctrl #(
        .MULT_LAT (MULT_LAT),
        .RES_DEPTH(RES_DEPTH)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: combinational product plus two register stages.
    logic [127:0] ea, eb, mprod, pd1, pd2;
    always_comb begin
        ea = {{64{bus.o_mult_a_ns & bus.o_mult_a[63]}}, bus.o_mult_a};
        eb = {{64{bus.o_mult_b_ns & bus.o_mult_b[63]}}, bus.o_mult_b};
        mprod = ea * eb;
    end
    always @(posedge clk) begin
        pd1 <= mprod;
        pd2 <= pd1;
    end
    assign bus.i_mult_p = pd2;

    logic [63:0]  t0_a [4] = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'h1_0000_0000, 64'd10};
    logic [63:0]  t0_b [4] = '{64'd5, 64'd2, 64'h1_0000_0000, 64'd20};
    logic         t0_an [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic         t0_bn [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [127:0] t0_p [4] = '{
        128'd15,
        128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE,
        128'h0000_0000_0000_0001_0000_0000_0000_0000,
        128'd200};

    logic [63:0]  t1_a [4] = '{64'hFFFF_FFFF_FFFF_FFFE,
                               64'hFFFF_FFFF_FFFF_FFFF,
                               64'hFFFF_FFFF_FFFF_FFFF, 64'd7};
    logic [63:0]  t1_b [4] = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'hFFFF_FFFF_FFFF_FFFF,
                               64'hFFFF_FFFF_FFFF_FFFF};
    logic         t1_an [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic         t1_bn [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [127:0] t1_p [4] = '{
        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA,
        128'd1,
        128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001,
        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF9};

    logic [128:0] sb_q [$];
    logic [127:0] cur_exp0, cur_exp1;
    logic         vld0, vld1, one_shot;
    int           idx0, idx1, acc_cyc;

    function automatic void check(string name, logic [127:0] act,
                                  logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic drive();
        bus.i_req0_valid = vld0;
        bus.i_req0_a     = t0_a[idx0];
        bus.i_req0_b     = t0_b[idx0];
        bus.i_req0_a_ns  = t0_an[idx0];
        bus.i_req0_b_ns  = t0_bn[idx0];
        cur_exp0         = t0_p[idx0];
        bus.i_req1_valid = vld1;
        bus.i_req1_a     = t1_a[idx1];
        bus.i_req1_b     = t1_b[idx1];
        bus.i_req1_a_ns  = t1_an[idx1];
        bus.i_req1_b_ns  = t1_bn[idx1];
        cur_exp1         = t1_p[idx1];
    endtask

    // One cycle: report which requester (if any) is accepted at the edge.
    task automatic step(output int acc);
        @(negedge clk);
        acc = -1;
        if (bus.i_req0_valid && bus.o_req0_ready) acc = 0;
        else if (bus.i_req1_valid && bus.o_req1_ready) acc = 1;
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        if (acc == 0) begin
            idx0 = (idx0 + 1) % 4;
            if (one_shot) vld0 = 1'b0;
        end
        if (acc == 1) begin
            idx1 = (idx1 + 1) % 4;
            if (one_shot) vld1 = 1'b0;
        end
        drive();
    endtask

    task automatic drain();
        vld0 = 1'b0;
        vld1 = 1'b0;
        bus.i_res_ready = 1'b1;
        drive();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus.o_busy && sb_q.size() == 0) break;
        end
        check("drain_idle", 128'(bus.o_busy), 128'd0);
        check("drain_sb_empty", 128'(sb_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every result handshake; push on accepts.
    initial begin
        logic         hold;
        logic [127:0] hp;
        logic         hid;
        logic [128:0] e;
        hold = 1'b0;
        hp = '0;
        hid = 1'b0;
        forever begin
            @(negedge clk);
            if (hold && bus.o_res_valid) begin
                check("res_p_stable", bus.o_res_p, hp);
                check("res_id_stable", 128'(bus.o_res_id), 128'(hid));
            end
            if (bus.o_res_valid && bus.i_res_ready) begin
                if (sb_q.size() == 0) begin
                    check("res_unexpected", 128'(bus.o_res_valid), 128'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("res_p", bus.o_res_p, e[127:0]);
                    check("res_id", 128'(bus.o_res_id), 128'(e[128]));
                end
            end
            hold = bus.o_res_valid && !bus.i_res_ready;
            hp   = bus.o_res_p;
            hid  = bus.o_res_id;
            if (bus.i_req0_valid && bus.o_req0_ready)
                sb_q.push_back({1'b0, cur_exp0});
            if (bus.i_req1_valid && bus.o_req1_ready)
                sb_q.push_back({1'b1, cur_exp1});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n, expg, a_cyc;
        logic got;
        rst = 1'b1;
        bus.i_res_ready = 1'b1;
        vld0 = 1'b1;
        vld1 = 1'b1;
        one_shot = 1'b0;
        idx0 = 0;
        idx1 = 0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", 128'(bus.o_req0_ready), 128'd0);
        check("rst_ready1", 128'(bus.o_req1_ready), 128'd0);
        check("rst_res_valid", 128'(bus.o_res_valid), 128'd0);
        check("rst_busy", 128'(bus.o_busy), 128'd0);
        check("rst_res_p", bus.o_res_p, 128'd0);
        check("rst_res_id", 128'(bus.o_res_id), 128'd0);
        check("rst_mult_a", 128'(bus.o_mult_a), 128'd0);
        check("rst_mult_b", 128'(bus.o_mult_b), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Contention from reset: grants must alternate starting with 0.
        expg = 0;
        n = 0;
        for (int k = 0; k < 60 && n < 8; k++) begin
            step(acc);
            if (acc >= 0) begin
                check("grant_order", 128'(acc), 128'(expg));
                expg ^= 1;
                n++;
            end
        end
        check("contention_accepts", 128'(n), 128'd8);
        drain();

        // Single unsigned op with latency and busy check.
        idx0 = 0;
        vld0 = 1'b1;
        one_shot = 1'b1;
        drive();
        acc = -1;
        for (int k = 0; k < 20 && acc < 0; k++) step(acc);
        check("single_acc", 128'(acc), 128'd0);
        a_cyc = acc_cyc;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = bus.o_res_valid;
        end
        check("single_lat", 128'(cyc - a_cyc), 128'(MULT_LAT + 1));
        check("single_p", bus.o_res_p, 128'd15);
        check("single_id", 128'(bus.o_res_id), 128'd0);
        @(negedge clk);
        check("single_busy_low", 128'(bus.o_busy), 128'd0);
        drain();

        // Signed op on requester 1.
        idx1 = 0;
        vld1 = 1'b1;
        drive();
        acc = -1;
        for (int k = 0; k < 20 && acc < 0; k++) step(acc);
        check("signed_acc", 128'(acc), 128'd1);
        drain();

        // Backpressure: credits stop accepts at RES_DEPTH.
        idx0 = 0;
        idx1 = 0;
        one_shot = 1'b0;
        bus.i_res_ready = 1'b0;
        vld0 = 1'b1;
        vld1 = 1'b1;
        drive();
        n = 0;
        for (int k = 0; k < 12; k++) begin
            step(acc);
            if (acc >= 0) n++;
        end
        check("bp_accepts", 128'(n), 128'(RES_DEPTH));
        bus.i_res_ready = 1'b1;
        step(acc);
        check("bp_pop_no_credit", 128'(acc), 128'(-1));
        bus.i_res_ready = 1'b0;
        step(acc);
        check("bp_next_accept", 128'(acc), 128'd0);
        step(acc);
        check("bp_full_again", 128'(acc), 128'(-1));
        drain();

        // Reset two cycles after an accept discards the op.
        idx0 = 0;
        vld0 = 1'b1;
        one_shot = 1'b1;
        drive();
        acc = -1;
        for (int k = 0; k < 20 && acc < 0; k++) step(acc);
        check("mid_acc", 128'(acc), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("mid_rst_busy", 128'(bus.o_busy), 128'd0);
        check("mid_rst_ready0", 128'(bus.o_req0_ready), 128'd0);
        check("mid_rst_res_valid", 128'(bus.o_res_valid), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            got = got | bus.o_res_valid;
        end
        check("mid_no_result", 128'(got), 128'd0);
        check("mid_busy", 128'(bus.o_busy), 128'd0);
        @(posedge clk);
        #1;
        vld0 = 1'b1;
        vld1 = 1'b1;
        drive();
        acc = -1;
        for (int k = 0; k < 20 && acc < 0; k++) step(acc);
        check("mid_first_grant", 128'(acc), 128'd0);
        drain();

        check("final_sb_empty", 128'(sb_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
